piece_controller: RTL and testbench

Sequencer for the active falling tetromino. It owns the current piece state (type, orientation, x, y), arbitrates gravity, player move and rotate requests, and validates each candidate position through a handshake with the board collision checker. It also commits landed pieces to the board and waits out line clears before spawning the next piece. It sits between the input/RNG front end and the board-memory/collision block.

---
 rtl/piece_controller_pkg.sv | 78 +++++++
 rtl/piece_controller_if.sv | 68 ++++++
 rtl/piece_controller_gravity_timer.sv | 53 +++++
 rtl/piece_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_piece_controller.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/piece_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piece_controller_pkg
// Purpose  : Shared types for the falling-piece sequencer: tetromino kinds,
//            orientations, move directions, controller states, the piece
//            state record and rotation helpers.
//            Board geometry lives here because the signed coordinate widths
//            of the shared piece record derive from it.
// Revision : 1.0 - initial release
// ============================================================================
package piece_controller_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int X_W     = $clog2(BOARD_W) + 2;
  localparam int Y_W     = $clog2(BOARD_H) + 2;

  typedef enum logic [2:0] {
    I_CYAN    = 3'd0,
    O_YELLOW  = 3'd1,
    T_MAGENTA = 3'd2,
    S_GREEN   = 3'd3,
    Z_RED     = 3'd4,
    J_BLUE    = 3'd5,
    L_ORANGE  = 3'd6
  } block_t;

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    ROT_RIGHT1 = 2'd1,
    ROT2       = 2'd2,
    ROT_LEFT1  = 2'd3
  } orientation;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2
  } direction;

  typedef enum logic [2:0] {
    PC_IDLE       = 3'd0,
    PC_SPAWN      = 3'd1,
    PC_SPAWN_CHK  = 3'd2,
    PC_WAIT       = 3'd3,
    PC_CHECK      = 3'd4,
    PC_LOCK       = 3'd5,
    PC_CLEAR_WAIT = 3'd6,
    PC_OVER       = 3'd7
  } pc_state_t;

  // What produced the candidate currently under check; decides hit handling.
  typedef enum logic [2:0] {
    KIND_SHIFT = 3'd0,
    KIND_ROT   = 3'd1,
    KIND_SOFT  = 3'd2,
    KIND_GRAV  = 3'd3,
    KIND_HARD  = 3'd4
  } chk_kind_t;

  typedef struct packed {
    block_t                  piece;
    orientation              orient;
    logic signed [X_W-1:0]   x;
    logic signed [Y_W-1:0]   y;
  } piece_state_t;

  // Orientation encoding is cyclic, so rotation is a 2-bit wrap-around step.
  function automatic orientation rot_cw(input orientation o);
    return orientation'(o + 2'd1);
  endfunction

  function automatic orientation rot_ccw(input orientation o);
    return orientation'(o - 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piece_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : piece_controller_if
// Purpose  : Bundle of all non-clock signals between the piece sequencer and
//            its environment (input/RNG front end, collision checker, board).
// Modports : master - the piece_controller side
//            slave  - the environment side
// Signals  : start, frame_tick, move_req/move_dir, rot_req/rot_cw,
//            next_piece/next_take, chk_* query/response, lock_valid/ready,
//            clear_busy, cur_* render state, piece_active, game_over.
//            hard_drop_req exists only when HARD_DROP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface piece_controller_if;
  import piece_controller_pkg::*;

  logic                  start;
  logic                  frame_tick;
  logic                  move_req;
  direction              move_dir;
  logic                  rot_req;
  logic                  rot_cw;
  block_t                next_piece;
  logic                  next_take;
  logic                  chk_req;
  block_t                chk_piece;
  orientation            chk_orient;
  logic signed [X_W-1:0] chk_x;
  logic signed [Y_W-1:0] chk_y;
  logic                  chk_done;
  logic                  chk_hit;
  logic                  lock_valid;
  logic                  lock_ready;
  logic                  clear_busy;
  block_t                cur_piece;
  orientation            cur_orient;
  logic signed [X_W-1:0] cur_x;
  logic signed [Y_W-1:0] cur_y;
  logic                  piece_active;
  logic                  game_over;
`ifdef HARD_DROP_EN
  logic                  hard_drop_req;
`endif

  modport master (
    input  start, frame_tick, move_req, move_dir, rot_req, rot_cw,
           next_piece, chk_done, chk_hit, lock_ready, clear_busy,
    output next_take, chk_req, chk_piece, chk_orient, chk_x, chk_y,
           lock_valid, cur_piece, cur_orient, cur_x, cur_y,
           piece_active, game_over
`ifdef HARD_DROP_EN
    , input hard_drop_req
`endif
  );

  modport slave (
    output start, frame_tick, move_req, move_dir, rot_req, rot_cw,
           next_piece, chk_done, chk_hit, lock_ready, clear_busy,
    input  next_take, chk_req, chk_piece, chk_orient, chk_x, chk_y,
           lock_valid, cur_piece, cur_orient, cur_x, cur_y,
           piece_active, game_over
`ifdef HARD_DROP_EN
    , output hard_drop_req
`endif
  );

endinterface
`default_nettype wire

// File: rtl/piece_controller_gravity_timer.sv
`default_nettype none
// ============================================================================
// Module   : gravity_timer
// Purpose  : Counts frame ticks while enabled; emits a one-cycle wrap pulse
//            on the tick that reaches GRAVITY_FRAMES-1 and restarts from 0.
// Ports    : clk, rst_n (async, active low), en (count enable), tick (frame
//            pulse), clr (synchronous clear, wins over counting),
//            wrap (combinational pulse, one per GRAVITY_FRAMES ticks)
// Revision : 1.0 - initial release
// ============================================================================
module gravity_timer #(
  parameter int GRAVITY_FRAMES = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick,
  input  logic clr,
  output logic wrap
);

  // A single-frame period still needs a 1-bit counter to stay legal.
  localparam int              CNT_W    = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAVITY_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piece_controller.sv
`default_nettype none
// ============================================================================
// Module   : piece_controller
// Purpose  : Sequencer for the active falling tetromino. Owns the current
//            piece state, arbitrates gravity / rotate / move requests,
//            validates candidates through the collision-check handshake,
//            commits landed pieces and waits out line clears before the next
//            spawn.
// Ports    : clk, rst_n (async, active low)
//            bus - piece_controller_if.master (requests, RNG, checker,
//                  board lock, render state, game_over)
// Config   : HARD_DROP_EN - adds bus.hard_drop_req: repeated y+1 checks
//            committing each free row until a hit, then lock.
// Revision : 1.0 - initial release
// ============================================================================
module piece_controller #(
  parameter int GRAVITY_FRAMES = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  piece_controller_if.master        bus
);
  import piece_controller_pkg::*;

  localparam logic [2:0] ST_IDLE       = PC_IDLE;
  localparam logic [2:0] ST_SPAWN      = PC_SPAWN;
  localparam logic [2:0] ST_SPAWN_CHK  = PC_SPAWN_CHK;
  localparam logic [2:0] ST_WAIT       = PC_WAIT;
  localparam logic [2:0] ST_CHECK      = PC_CHECK;
  localparam logic [2:0] ST_LOCK       = PC_LOCK;
  localparam logic [2:0] ST_CLEAR_WAIT = PC_CLEAR_WAIT;
  localparam logic [2:0] ST_OVER       = PC_OVER;

  localparam logic signed [X_W-1:0] SPAWN_X = X_W'(BOARD_W / 2 - 2);

  logic [2:0]   state_q, state_d;
  piece_state_t cur_q, cur_d;
  piece_state_t cand_q, cand_d;
  chk_kind_t    kind_q, kind_d;
  logic         active_q, active_d;
  logic         over_q, over_d;
  logic         grav_pend_q, grav_pend_d;
  logic         pend_clr;
  logic         grav_clr;
  logic         grav_wrap;
  piece_state_t spawn_state;

  assign spawn_state = '{piece: bus.next_piece, orient: NORMAL, x: SPAWN_X, y: '0};

  gravity_timer #(
    .GRAVITY_FRAMES (GRAVITY_FRAMES)
  ) u_gravity_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state_q == ST_WAIT) || (state_q == ST_CHECK)),
    .tick  (bus.frame_tick),
    .clr   (grav_clr),
    .wrap  (grav_wrap)
  );

  // A wrap in the same cycle a gravity check is issued is a new period and
  // must survive, so the set term dominates the clear.
  assign grav_pend_d = grav_wrap | (grav_pend_q & ~pend_clr);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cand_d   = cand_q;
    kind_d   = kind_q;
    active_d = active_q;
    over_d   = over_q;
    pend_clr = 1'b0;
    grav_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d = ST_SPAWN;
          over_d  = 1'b0;
        end
      end
      ST_SPAWN: begin
        cur_d    = spawn_state;
        cand_d   = spawn_state;
        grav_clr = 1'b1;
        state_d  = ST_SPAWN_CHK;
      end
      ST_SPAWN_CHK: begin
        if (bus.chk_done) begin
          if (bus.chk_hit) begin
            state_d  = ST_OVER;
            over_d   = 1'b1;
            active_d = 1'b0;
          end else begin
            state_d  = ST_WAIT;
            active_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cand_d = cur_q;
`ifdef HARD_DROP_EN
        if (bus.hard_drop_req) begin
          cand_d.y = cur_q.y + Y_W'(1);
          kind_d   = KIND_HARD;
          state_d  = ST_CHECK;
        end else if (grav_pend_q) begin
`else
        if (grav_pend_q) begin
`endif
          cand_d.y = cur_q.y + Y_W'(1);
          kind_d   = KIND_GRAV;
          pend_clr = 1'b1;
          state_d  = ST_CHECK;
        end else if (bus.rot_req) begin
          // The O piece is rotation-symmetric; the request is swallowed.
          if (cur_q.piece != O_YELLOW) begin
            cand_d.orient = bus.rot_cw ? rot_cw(cur_q.orient) : rot_ccw(cur_q.orient);
            kind_d        = KIND_ROT;
            state_d       = ST_CHECK;
          end
        end else if (bus.move_req) begin
          case (bus.move_dir)
            LEFT: begin
              cand_d.x = cur_q.x - X_W'(1);
              kind_d   = KIND_SHIFT;
              state_d  = ST_CHECK;
            end
            RIGHT: begin
              cand_d.x = cur_q.x + X_W'(1);
              kind_d   = KIND_SHIFT;
              state_d  = ST_CHECK;
            end
            DOWN: begin
              cand_d.y = cur_q.y + Y_W'(1);
              kind_d   = KIND_SOFT;
              state_d  = ST_CHECK;
            end
            default: ;
          endcase
        end
      end
      ST_CHECK: begin
        if (bus.chk_done) begin
          if (!bus.chk_hit) begin
            cur_d   = cand_q;
            state_d = ST_WAIT;
            if (kind_q == KIND_SOFT) begin
              grav_clr = 1'b1;
            end
`ifdef HARD_DROP_EN
            // Keep falling: next row is queried straight away.
            if (kind_q == KIND_HARD) begin
              cand_d.y = cand_q.y + Y_W'(1);
              state_d  = ST_CHECK;
            end
`endif
          end else if (kind_q inside {KIND_SOFT, KIND_GRAV, KIND_HARD}) begin
            state_d = ST_LOCK;
`ifdef HARD_DROP_EN
            if (kind_q == KIND_HARD) begin
              pend_clr = 1'b1;
            end
`endif
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_LOCK: begin
        if (bus.lock_ready) begin
          active_d = 1'b0;
          state_d  = ST_CLEAR_WAIT;
        end
      end
      ST_CLEAR_WAIT: begin
        if (!bus.clear_busy) begin
          state_d = ST_SPAWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      cand_q      <= '0;
      kind_q      <= KIND_SHIFT;
      active_q    <= 1'b0;
      over_q      <= 1'b0;
      grav_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cand_q      <= cand_d;
      kind_q      <= kind_d;
      active_q    <= active_d;
      over_q      <= over_d;
      grav_pend_q <= grav_pend_d;
    end
  end

  // Handshake valids decode straight from state so an async reset drops them
  // at once; candidate and cur_* come from flops held steady meanwhile.
  assign bus.next_take    = (state_q == ST_SPAWN);
  assign bus.chk_req      = (state_q == ST_SPAWN_CHK) || (state_q == ST_CHECK);
  assign bus.lock_valid   = (state_q == ST_LOCK);
  assign bus.chk_piece    = cand_q.piece;
  assign bus.chk_orient   = cand_q.orient;
  assign bus.chk_x        = cand_q.x;
  assign bus.chk_y        = cand_q.y;
  assign bus.cur_piece    = cur_q.piece;
  assign bus.cur_orient   = cur_q.orient;
  assign bus.cur_x        = cur_q.x;
  assign bus.cur_y        = cur_q.y;
  assign bus.piece_active = active_q;
  assign bus.game_over    = over_q;

endmodule
`default_nettype wire

// File: tb/tb_piece_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_piece_controller
// Purpose  : Directed self-checking bench for piece_controller with a
//            two-frame gravity period and a scripted collision checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piece_controller;
  import piece_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic hit_cfg;
  logic resp_en;
  int   errors    = 0;
  int   checks    = 0;
  int   chk_count = 0;
  int   lock_hi;
  logic found;
  logic nt_seen;

  piece_controller_if bus ();

  piece_controller #(
    .GRAVITY_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Same-cycle collision checker: answers any open query on the low phase.
  initial begin
    bus.chk_done = 1'b0;
    bus.chk_hit  = 1'b0;
    forever begin
      @(negedge clk);
      bus.chk_done = bus.chk_req && resp_en;
      bus.chk_hit  = bus.chk_req && resp_en && hit_cfg;
    end
  end

  always @(posedge clk) begin
    if (bus.chk_req && bus.chk_done) chk_count <= chk_count + 1;
  end

  task automatic frame_pulse(input int idle);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic do_move(input direction d);
    bus.move_req = 1'b1;
    bus.move_dir = d;
    @(negedge clk);
    bus.move_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.frame_tick = 1'b0;
    bus.move_req   = 1'b0;
    bus.move_dir   = LEFT;
    bus.rot_req    = 1'b0;
    bus.rot_cw     = 1'b0;
    bus.next_piece = T_MAGENTA;
    bus.lock_ready = 1'b0;
    bus.clear_busy = 1'b0;
`ifdef HARD_DROP_EN
    bus.hard_drop_req = 1'b0;
`endif
    hit_cfg = 1'b0;
    resp_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state",     dut.state_q,      0);
    check("rst_chk_req",   bus.chk_req,      0);
    check("rst_lock",      bus.lock_valid,   0);
    check("rst_active",    bus.piece_active, 0);
    check("rst_over",      bus.game_over,    0);
    check("rst_piece",     bus.cur_piece,    I_CYAN);
    check("rst_orient",    bus.cur_orient,   NORMAL);
    check("rst_take",      bus.next_take,    0);
    rst_n = 1'b1;

    // Spawn T piece at (3,0)
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("spawn_take",    bus.next_take,    1);
    @(negedge clk);
    check("spawn_chk_req", bus.chk_req,      1);
    check("take_pulse",    bus.next_take,    0);
    check("spawn_chk_x",   bus.chk_x,        3);
    check("spawn_piece",   bus.cur_piece,    T_MAGENTA);
    check("spawn_x",       bus.cur_x,        3);
    check("spawn_y",       bus.cur_y,        0);
    @(negedge clk);
    check("spawn_active",  bus.piece_active, 1);
    check("spawn_nchk",    chk_count,        1);

    // start ignored while playing
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("start_ign",     bus.next_take,    0);

    // Gravity: one check per two frame ticks
    frame_pulse(4);
    check("grav1_y",       bus.cur_y,        0);
    check("grav1_nchk",    chk_count,        1);
    frame_pulse(4);
    check("grav2_y",       bus.cur_y,        1);
    check("grav2_nchk",    chk_count,        2);
    frame_pulse(1);
    frame_pulse(4);
    check("grav4_y",       bus.cur_y,        2);
    check("grav4_nchk",    chk_count,        3);

    // Rotate beats move in the same cycle
    bus.rot_req = 1'b1; bus.rot_cw = 1'b1;
    bus.move_req = 1'b1; bus.move_dir = RIGHT;
    @(negedge clk);
    bus.rot_req = 1'b0; bus.move_req = 1'b0;
    check("rot_chk_req",   bus.chk_req,      1);
    check("rot_chk_or",    bus.chk_orient,   ROT_RIGHT1);
    check("rot_chk_x",     bus.chk_x,        3);
    @(negedge clk);
    check("rot_orient",    bus.cur_orient,   ROT_RIGHT1);
    check("rot_x",         bus.cur_x,        3);
    @(negedge clk);
    check("rot_only",      chk_count,        4);

    // Left, then soft drop resets gravity phase
    do_move(LEFT);
    check("left_x",        bus.cur_x,        2);
    frame_pulse(1);
    do_move(DOWN);
    check("soft_y",        bus.cur_y,        3);
    frame_pulse(4);
    check("soft_clr_y",    bus.cur_y,        3);
    check("soft_clr_nchk", chk_count,        6);

    // Blocked shift is discarded, no lock
    hit_cfg = 1'b1;
    @(negedge clk);
    do_move(RIGHT);
    check("hit_x",         bus.cur_x,        2);
    check("hit_nchk",      chk_count,        7);
    check("hit_nolock",    bus.lock_valid,   0);
    check("hit_active",    bus.piece_active, 1);

    // Gravity hit -> lock, ready after 3 cycles, clear_busy 5 cycles
    frame_pulse(0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.lock_valid) found = 1'b1;
    end
    check("lock_seen",     found,            1);
    check("lock_y",        bus.cur_y,        3);
    check("lock_nchk",     chk_count,        8);
    lock_hi = 1;
    @(negedge clk); if (bus.lock_valid) lock_hi++;
    @(negedge clk); if (bus.lock_valid) lock_hi++;
    bus.lock_ready = 1'b1;
    bus.clear_busy = 1'b1;
    bus.next_piece = O_YELLOW;
    @(negedge clk);
    bus.lock_ready = 1'b0;
    check("lock_hi",       lock_hi,          3);
    check("lock_drop",     bus.lock_valid,   0);
    check("lock_inactive", bus.piece_active, 0);
    nt_seen = bus.next_take;
    repeat (4) begin
      @(negedge clk);
      if (bus.next_take) nt_seen = 1'b1;
    end
    bus.clear_busy = 1'b0;
    check("clr_hold",      nt_seen,          0);
    @(negedge clk);
    check("clr_spawn",     bus.next_take,    1);

    // Spawn collides -> game over
    @(negedge clk);
    check("over_chk_req",  bus.chk_req,      1);
    @(negedge clk);
    check("over_flag",     bus.game_over,    1);
    check("over_active",   bus.piece_active, 0);
    check("over_piece",    bus.cur_piece,    O_YELLOW);
    hit_cfg = 1'b0;
    bus.next_piece = L_ORANGE;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_over",  bus.game_over,    0);
    check("restart_take",  bus.next_take,    1);
    repeat (2) @(negedge clk);
    check("restart_act",   bus.piece_active, 1);
    check("restart_piece", bus.cur_piece,    L_ORANGE);
    check("restart_x",     bus.cur_x,        3);
    resp_en = 1'b0;

    // Reset while a check is outstanding
    @(negedge clk);
    bus.move_req = 1'b1; bus.move_dir = LEFT;
    @(negedge clk);
    bus.move_req = 1'b0;
    check("pend_chk_req",  bus.chk_req,      1);
    check("pend_chk_x",    bus.chk_x,        2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_chk_req",  bus.chk_req,      0);
    check("arst_lock",     bus.lock_valid,   0);
    check("arst_active",   bus.piece_active, 0);
    check("arst_piece",    bus.cur_piece,    I_CYAN);
    check("arst_x",        bus.cur_x,        0);
    check("arst_state",    dut.state_q,      0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
